// File: rtl/encoder_round_sequencer.sv
// Round/stage sequencer for the encoder permutation.
// Runs NUM_STAGES step units in order for NUM_ROUNDS rounds. Each unit is driven
// through a start/ready handshake, and every stage is guarded by a wait timeout.
// All outputs are decoded from the registered state and counters.
module encoder_round_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_ROUNDS = 24,
    parameter int RW         = 5,
    parameter int SW         = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  ld_input,
    output logic                  state_we,
    output logic [RW-1:0]         round,
    output logic [SW-1:0]         stage_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // The timer only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_KICK = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic          ready_cur;

    // Pick out the ready bit of the current unit; all other bits are ignored.
    always_comb begin
        ready_cur = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_idx == SW'(i)) ready_cur = stage_ready[i];
        end
    end

    // Main FSM with the round, stage and timeout counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            round     <= '0;
            stage_idx <= '0;
            timer     <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    round     <= '0;
                    stage_idx <= '0;
                    state     <= S_KICK;
                end
                S_KICK: begin
                    // Ready is not looked at here, so an idle-high ready cannot
                    // complete the stage before the unit has even started.
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ready_cur)                state <= S_NEXT;
                    else if (timer == TIMER_LAST) state <= S_ERR;
                    else                          timer <= timer + 1'b1;
                end
                S_NEXT: begin
                    if (stage_idx < LAST_STAGE) begin
                        stage_idx <= stage_idx + 1'b1;
                        state     <= S_KICK;
                    end else if (round < LAST_ROUND) begin
                        round     <= round + 1'b1;
                        stage_idx <= '0;
                        state     <= S_KICK;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore output decode; error is sticky because ERR holds until a new start.
    always_comb begin
        stage_start = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_start[i] = (state == S_KICK) && (stage_idx == SW'(i));
        end
        ld_input = (state == S_LOAD);
        state_we = (state == S_NEXT);
        done     = (state == S_DONE);
        error    = (state == S_ERR);
        busy     = (state == S_LOAD) || (state == S_KICK) || (state == S_WAIT) ||
                   (state == S_NEXT) || (state == S_DONE);
    end

endmodule

// File: tb/tb_encoder_round_sequencer.sv
// Scoreboard bench for encoder_round_sequencer. A timing model predicts the
// cycle of every observable event (load, stage start, write-back, done, error)
// from the per-stage response delays; a monitor matches DUT events against it.
module tb_encoder_round_sequencer;

    localparam int NS    = 5;
    localparam int NR    = 2;
    localparam int RW    = 5;
    localparam int SW    = 3;
    localparam int TO    = 8;
    localparam int NEVER = 1000;
    localparam int BIG   = 1 << 30;

    localparam int K_LD = 0;
    localparam int K_ST = 1;
    localparam int K_WE = 2;
    localparam int K_DN = 3;
    localparam int K_ER = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [NS-1:0] ss;
        int          rnd;
        int          sidx;
        bit          chk_rs;
        bit          bsy;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NS-1:0] stage_ready;
    logic [NS-1:0] stage_start;
    logic          ld_input;
    logic          state_we;
    logic [RW-1:0] round;
    logic [SW-1:0] stage_idx;
    logic          busy;
    logic          done;
    logic          error;

    encoder_round_sequencer #(
        .NUM_STAGES(NS), .NUM_ROUNDS(NR), .RW(RW), .SW(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stage_ready(stage_ready),
        .stage_start(stage_start), .ld_input(ld_input), .state_we(state_we),
        .round(round), .stage_idx(stage_idx), .busy(busy), .done(done),
        .error(error)
    );

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  we_cnt = 0;
    int  last_done = -1;
    bit  stray_en = 0;
    int  dly [NR][NS];
    ev_t exp_q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int r, input int s,
                           input bit chk_rs, input bit bsy, input int limit);
        ev_t e;
        logic [NS-1:0] one;
        one = 1;
        e.kind = kind; e.cyc = c; e.rnd = r; e.sidx = s;
        e.chk_rs = chk_rs; e.bsy = bsy;
        e.ss = (kind == K_ST) ? (one << s) : '0;
        if (c <= limit) exp_q.push_back(e);
    endtask

    // Timing model: load 1 cycle after the start edge, then each stage is a
    // start cycle, 1+delay wait cycles and a write-back cycle; done follows the
    // last write-back. A stage that never answers errors after TO wait cycles.
    task automatic model(input int c0, input int limit, output int endc);
        int cur;
        push_ev(K_LD, c0 + 1, 0, 0, 0, 1, limit);
        cur = c0 + 2;
        for (int r = 0; r < NR; r++) begin
            for (int s = 0; s < NS; s++) begin
                push_ev(K_ST, cur, r, s, 1, 1, limit);
                if (dly[r][s] >= TO) begin
                    endc = cur + 1 + TO;
                    push_ev(K_ER, endc, r, s, 1, 0, limit);
                    return;
                end
                push_ev(K_WE, cur + 2 + dly[r][s], r, s, 1, 1, limit);
                cur = cur + 3 + dly[r][s];
            end
        end
        endc = cur;
        push_ev(K_DN, cur, NR - 1, NS - 1, 1, 1, limit);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d want=none", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || stage_start != e.ss || busy != e.bsy ||
            (e.chk_rs && (int'(round) != e.rnd || int'(stage_idx) != e.sidx))) begin
            bad++;
            $display("FAIL event got kind=%0d cyc=%0d ss=%b r=%0d s=%0d busy=%b want kind=%0d cyc=%0d ss=%b r=%0d s=%0d busy=%b",
                     kind, cyc, stage_start, round, stage_idx, busy,
                     e.kind, e.cyc, e.ss, e.rnd, e.sidx, e.bsy);
        end
    endtask

    // Monitor: every visible event pops and checks the scoreboard head.
    initial begin
        bit err_prev;
        err_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ld_input)          observe(K_LD);
                if (stage_start != 0)  observe(K_ST);
                if (state_we) begin
                    observe(K_WE);
                    we_cnt++;
                end
                if (done) begin
                    observe(K_DN);
                    last_done = cyc;
                end
                if (error && !err_prev) observe(K_ER);
            end
            err_prev = error;
        end
    end

    // Responder: pulses the current unit's ready after its configured delay,
    // optionally adding stray ready bits that the DUT must ignore.
    initial begin
        int pend, ps, s;
        logic [NS-1:0] rdy, msk;
        pend = 0; ps = 0;
        stage_ready = '0;
        forever begin
            @(negedge clk);
            rdy = '0;
            if (!rst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) rdy[ps] = 1'b1;
                end
                if (stage_start != 0) begin
                    s = 0;
                    for (int i = 0; i < NS; i++) if (stage_start[i]) s = i;
                    pend = 0;
                    if (int'(round) < NR && dly[round][s] < TO) begin
                        pend = dly[round][s] + 1;
                        ps = s;
                    end
                end
                if (stray_en) begin
                    msk = NS'($urandom());
                    if (int'(stage_idx) < NS) begin
                        if (stage_start != 0) msk[stage_idx] = 1'b1;
                        else                  msk[stage_idx] = 1'b0;
                    end
                    rdy = rdy | msk;
                end
            end
            stage_ready = rdy;
        end
    end

    task automatic clear_dly();
        for (int r = 0; r < NR; r++)
            for (int s = 0; s < NS; s++) dly[r][s] = 0;
    endtask

    task automatic go(input int lim_off, output int c0, output int endc);
        @(negedge clk);
        start = 1;
        c0 = cyc;
        model(c0, (lim_off < 0) ? BIG : c0 + lim_off, endc);
        @(negedge clk);
        start = 0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending=%0d want=0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_stage_start"}, int'(stage_start), 0);
        chk({nm, "_ld_we_done"}, int'({ld_input, state_we, done}), 0);
        chk({nm, "_busy_error"}, int'({busy, error}), 0);
        chk({nm, "_round_idx"}, int'({round, stage_idx}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want=finished", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int c0, endc, e2, we0, n;
        rst = 0; start = 0;
        clear_dly();

        // Reset values, then idle with start low.
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst = 1;
        repeat (4) @(negedge clk);
        chk_quiet("idle");

        // Nominal run: every unit answers in its first wait cycle.
        we0 = we_cnt;
        go(-1, c0, endc);
        drain("nominal", 100);
        chk("nominal_we_count", we_cnt - we0, 10);
        chk("nominal_done_cycle", last_done - c0, 32);

        // Slow unit: stage 3 answers 7 cycles late (last legal cycle), with strays.
        stray_en = 1;
        dly[0][3] = 7;
        go(-1, c0, endc);
        drain("slow", 120);
        chk("slow_done_cycle", last_done - c0, 39);
        stray_en = 0;
        clear_dly();

        // Timeout: stage 2 never answers; error is sticky, a new start clears it.
        dly[0][2] = NEVER;
        go(-1, c0, endc);
        drain("timeout", 100);
        repeat (3) @(negedge clk);
        chk("timeout_error_held", int'(error), 1);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_round_idx", int'(stage_idx), 2);
        clear_dly();
        go(-1, c0, endc);
        chk("rerun_error_cleared", int'(error), 0);
        chk("rerun_load", int'(ld_input), 1);
        drain("rerun", 100);
        chk("rerun_done_cycle", last_done - c0, 32);

        // start while busy is ignored.
        go(-1, c0, endc);
        repeat (6) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        drain("restart_ignored", 100);

        // Abort: reset mid-wait of stage 1, then a clean run.
        dly[0][1] = 5;
        go(8, c0, endc);
        n = 0;
        while (cyc < c0 + 8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1 rst = 0;
        #1 chk_quiet("abort_async");
        @(negedge clk);
        chk_quiet("abort_held");
        chk("abort_pending", exp_q.size(), 0);
        exp_q.delete();
        rst = 1;
        clear_dly();
        go(-1, c0, endc);
        drain("after_abort", 100);
        chk("after_abort_done_cycle", last_done - c0, 32);

        // Back-to-back: start held through done; next load after one idle cycle.
        @(negedge clk);
        start = 1;
        c0 = cyc;
        model(c0, BIG, endc);
        model(endc + 1, BIG, e2);
        n = 0;
        while (cyc < endc + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 0;
        drain("back_to_back", 100);
        chk("b2b_done_cycle", last_done - c0, 65);

        // Randomised delays, strays and occasional dead units.
        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < NR; r++)
                for (int s = 0; s < NS; s++) dly[r][s] = $urandom_range(0, TO - 1);
            if ($urandom_range(0, 3) == 0)
                dly[$urandom_range(0, NR - 1)][$urandom_range(0, NS - 1)] = NEVER;
            stray_en = ($urandom_range(0, 1) == 1);
            go(-1, c0, endc);
            drain("random", 300);
        end
        stray_en = 0;

        repeat (2) @(negedge clk);
        chk("final_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
